// File: rtl/pc_fetch_pkg.sv
// Shared encodings, state enum and vector defaults for the program-counter /
// instruction-fetch sequencer.
package pc_fetch_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    PCSEL_RESET  = 2'b00,
    PCSEL_INT    = 2'b01,
    PCSEL_SEQ    = 2'b10,
    PCSEL_BRANCH = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    BSEL_REL = 2'b00,
    BSEL_REG = 2'b01,
    BSEL_IMM = 2'b10
  } branch_sel_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DROP  = 2'b10
  } state_e;

  localparam addr_t DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam addr_t DEFAULT_INT_VEC   = 32'h0000_0180;
  localparam addr_t INST_BYTES        = 32'h0000_0004;

  // Signed word offset to a byte displacement.
  function automatic addr_t word_offset_bytes(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/ack bus plus the decode valid/ready handshake.
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  logic        imem_req;
  addr_t       imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  addr_t       inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );

endinterface

// File: rtl/pc_fetch_pc_next_mux.sv
// Next-PC selection from the address of the instruction being accepted and
// the branch-control decisions; purely combinational.
module pc_next_mux
  import pc_fetch_pkg::*;
#(
  parameter addr_t RESET_VEC = DEFAULT_RESET_VEC,
  parameter addr_t INT_VEC   = DEFAULT_INT_VEC
) (
  input  addr_t       inst_pc_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [1:0]  branch_sel_i,
  input  logic [15:0] branch_offset_i,
  input  logic [25:0] jump_index_i,
  input  addr_t       reg_target_i,
  output addr_t       next_pc_o
);

  addr_t seq_pc;

  assign seq_pc = inst_pc_i + INST_BYTES;

  // Select the next fetch address; reserved branch_sel falls through to PC+4.
  always_comb begin
    next_pc_o = seq_pc;
    case (pc_sel_i)
      PCSEL_RESET: next_pc_o = RESET_VEC;
      PCSEL_INT:   next_pc_o = INT_VEC;
      PCSEL_SEQ:   next_pc_o = seq_pc;
      PCSEL_BRANCH: begin
        case (branch_sel_i)
          BSEL_REL: next_pc_o = seq_pc + word_offset_bytes(branch_offset_i);
          BSEL_REG: next_pc_o = reg_target_i;
          BSEL_IMM: next_pc_o = {seq_pc[31:28], jump_index_i, 2'b00};
          default:  next_pc_o = seq_pc;
        endcase
      end
      default: next_pc_o = seq_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter and single-outstanding instruction-fetch sequencer with
// interrupt redirection.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter addr_t RESET_VEC = DEFAULT_RESET_VEC,
  parameter addr_t INT_VEC   = DEFAULT_INT_VEC
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [1:0]  branch_sel_i,
  input  logic [15:0] branch_offset_i,
  input  logic [25:0] jump_index_i,
  input  addr_t       reg_target_i,
  input  logic        irq_req_i,
  output logic        irq_ack_o,
  output addr_t       epc_o,
  pc_fetch_if.master  bus
);

  state_e      state_q, state_d;
  addr_t       pc_q, pc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  addr_t       inst_pc_q, inst_pc_d;
  addr_t       epc_q, epc_d;
  logic        irq_ack_q, irq_ack_d;
  addr_t       next_pc;
  logic        accept;

  assign accept = valid_q & bus.inst_ready;

  pc_next_mux #(
    .RESET_VEC (RESET_VEC),
    .INT_VEC   (INT_VEC)
  ) u_pc_next_mux (
    .inst_pc_i       (inst_pc_q),
    .pc_sel_i        (pc_sel_i),
    .branch_sel_i    (branch_sel_i),
    .branch_offset_i (branch_offset_i),
    .jump_index_i    (jump_index_i),
    .reg_target_i    (reg_target_i),
    .next_pc_o       (next_pc)
  );

  // Next-state and register updates for fetch, hold and interrupt drop.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    epc_d     = epc_q;
    irq_ack_d = 1'b0;
    case (state_q)
      FETCH: begin
        // req_q is low only in the first cycle out of reset; nothing is in flight then.
        if (req_q && bus.imem_ack) begin
          state_d   = HOLD;
          inst_d    = bus.imem_rdata;
          inst_pc_d = pc_q;
        end else if (req_q && irq_req_i) begin
          state_d = DROP;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (accept) begin
          state_d = FETCH;
          if (irq_req_i && (pc_sel_i != PCSEL_RESET)) begin
            epc_d     = next_pc;
            pc_d      = INT_VEC;
            irq_ack_d = 1'b1;
          end else begin
            pc_d = next_pc;
          end
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        if (req_q && bus.imem_ack) begin
          state_d   = FETCH;
          epc_d     = pc_q;
          pc_d      = INT_VEC;
          irq_ack_d = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    req_d   = (state_d != HOLD);
    valid_d = (state_d == HOLD);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VEC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= 32'h0000_0000;
      inst_pc_q <= 32'h0000_0000;
      epc_q     <= 32'h0000_0000;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      epc_q     <= epc_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign irq_ack_o      = irq_ack_q;
  assign epc_o          = epc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios followed by random
// transactions, all compared against a transaction-level reference model.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] IV = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pc_sel;
  logic [1:0]  branch_sel;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] reg_target;
  logic        irq_req;
  logic        irq_ack;
  logic [31:0] epc;

  pc_fetch_if bus ();

  pc_fetch #(.RESET_VEC(RV), .INT_VEC(IV)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .pc_sel_i        (pc_sel),
    .branch_sel_i    (branch_sel),
    .branch_offset_i (branch_offset),
    .jump_index_i    (jump_index),
    .reg_target_i    (reg_target),
    .irq_req_i       (irq_req),
    .irq_ack_o       (irq_ack),
    .epc_o           (epc),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: where the next fetch must go, what epc must hold,
  // whether an irq_ack pulse is due, and the instruction decode should see.
  logic [31:0] exp_pc;
  logic [31:0] exp_epc;
  bit          exp_ack_pulse;
  logic [31:0] exp_inst;
  logic [31:0] exp_inst_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] ipc, input logic [1:0] sel,
                                           input logic [1:0] bsel, input logic [15:0] off,
                                           input logic [25:0] idx, input logic [31:0] rt);
    logic [31:0] seq;
    seq = ipc + 32'd4;
    if (sel == 2'd0) return RV;
    if (sel == 2'd1) return IV;
    if (sel == 2'd2) return seq;
    if (bsel == 2'd0) return seq + 32'(int'($signed(off)) * 4);
    if (bsel == 2'd1) return rt;
    if (bsel == 2'd2) return (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
    return seq;
  endfunction

  task automatic do_reset(input int cycles, input bit stale_ack);
    reset = 1'b1;
    irq_req = 1'b0;
    bus.inst_ready = 1'b0;
    bus.imem_ack = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", bus.imem_addr, RV);
      check("rst_valid", 32'(bus.inst_valid), 32'd0);
      check("rst_inst", bus.inst, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'd0);
      check("rst_epc", epc, 32'd0);
      check("rst_irq_ack", 32'(irq_ack), 32'd0);
      bus.imem_ack = stale_ack;
      bus.imem_rdata = $urandom();
    end
    reset = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    exp_pc = RV;
    exp_epc = 32'd0;
    exp_ack_pulse = 1'b0;
  endtask

  // One fetch: wt wait cycles before ack. With irq_during the interrupt is
  // raised in the first (non-ack) cycle and the word must be dropped.
  task automatic fetch(input int wt, input bit irq_during, input logic [31:0] word,
                       output bit dropped);
    for (int i = 0; i <= wt; i++) begin
      check("fetch_req", 32'(bus.imem_req), 32'd1);
      check("fetch_addr", bus.imem_addr, exp_pc);
      check("irq_ack", 32'(irq_ack), (i == 0) ? 32'(exp_ack_pulse) : 32'd0);
      if (i == 0) begin
        check("epc", epc, exp_epc);
        check("fetch_valid_lo", 32'(bus.inst_valid), 32'd0);
      end
      bus.imem_ack = (i == wt);
      bus.imem_rdata = (i == wt) ? word : $urandom();
      bus.inst_ready = 1'($urandom_range(0, 1));
      if (irq_during) irq_req = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      else irq_req = 1'b0;
      tick();
    end
    bus.imem_ack = 1'b0;
    irq_req = 1'b0;
    exp_ack_pulse = 1'b0;
    if (irq_during) begin
      exp_epc = exp_pc;
      exp_pc = IV;
      exp_ack_pulse = 1'b1;
      dropped = 1'b1;
    end else begin
      exp_inst = word;
      exp_inst_pc = exp_pc;
      check("hold_valid", 32'(bus.inst_valid), 32'd1);
      check("hold_inst", bus.inst, exp_inst);
      check("hold_inst_pc", bus.inst_pc, exp_inst_pc);
      check("hold_req_lo", 32'(bus.imem_req), 32'd0);
      check("hold_irq_ack", 32'(irq_ack), 32'd0);
      dropped = 1'b0;
    end
  endtask

  // Decode stalls, then accepts with the given branch-control decision.
  task automatic decode(input int stall, input logic [1:0] sel, input logic [1:0] bsel,
                        input logic [15:0] off, input logic [25:0] idx,
                        input logic [31:0] rt, input bit irq);
    logic [31:0] nxt;
    for (int s = 0; s < stall; s++) begin
      bus.inst_ready = 1'b0;
      pc_sel = 2'($urandom());
      irq_req = 1'($urandom_range(0, 1));
      tick();
      check("stall_valid", 32'(bus.inst_valid), 32'd1);
      check("stall_inst", bus.inst, exp_inst);
      check("stall_inst_pc", bus.inst_pc, exp_inst_pc);
      check("stall_req_lo", 32'(bus.imem_req), 32'd0);
      check("stall_irq_ack", 32'(irq_ack), 32'd0);
    end
    bus.inst_ready = 1'b1;
    pc_sel = sel;
    branch_sel = bsel;
    branch_offset = off;
    jump_index = idx;
    reg_target = rt;
    irq_req = irq;
    tick();
    bus.inst_ready = 1'b0;
    irq_req = 1'b0;
    pc_sel = 2'($urandom());
    nxt = ref_next(exp_inst_pc, sel, bsel, off, idx, rt);
    if (irq && (sel != 2'd0)) begin
      exp_epc = nxt;
      exp_pc = IV;
      exp_ack_pulse = 1'b1;
    end else begin
      exp_pc = nxt;
    end
    check("accept_valid_lo", 32'(bus.inst_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit d;
    pc_sel = 2'd2;
    branch_sel = 2'd0;
    branch_offset = 16'd0;
    jump_index = 26'd0;
    reg_target = 32'd0;
    irq_req = 1'b0;
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.inst_ready = 1'b0;

    do_reset(2, 1'b0);

    // Sequential fetches 0x0, 0x4, 0x8 with zero-wait memory.
    check("first_fetch", bus.imem_addr, RV);
    fetch(0, 1'b0, $urandom(), d);
    decode(0, 2'd2, 2'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    check("seq_addr4", bus.imem_addr, 32'h4);
    fetch(0, 1'b0, $urandom(), d);
    decode(0, 2'd2, 2'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    check("seq_addr8", bus.imem_addr, 32'h8);
    fetch(1, 1'b0, $urandom(), d);

    // Branch flavours at a fixed inst_pc.
    decode(0, 2'd3, 2'd1, 16'd0, 26'd0, 32'h100, 1'b0);
    fetch(2, 1'b0, $urandom(), d);
    decode(0, 2'd3, 2'd0, 16'hFFFE, 26'd0, 32'd0, 1'b0);
    check("br_rel", bus.imem_addr, 32'hFC);
    fetch(0, 1'b0, $urandom(), d);
    decode(0, 2'd3, 2'd1, 16'd0, 26'd0, 32'h100, 1'b0);
    fetch(0, 1'b0, $urandom(), d);
    decode(0, 2'd3, 2'd1, 16'd0, 26'd0, 32'h2000, 1'b0);
    check("br_reg", bus.imem_addr, 32'h2000);
    fetch(0, 1'b0, $urandom(), d);
    decode(0, 2'd3, 2'd1, 16'd0, 26'd0, 32'h1000_0100, 1'b0);
    fetch(0, 1'b0, $urandom(), d);
    decode(0, 2'd3, 2'd2, 16'd0, 26'h40, 32'd0, 1'b0);
    check("br_imm", bus.imem_addr, 32'h1000_0100);
    fetch(0, 1'b0, $urandom(), d);

    // Three-cycle decode stall.
    decode(3, 2'd2, 2'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    check("stall_next", bus.imem_addr, 32'h1000_0104);
    fetch(0, 1'b0, $urandom(), d);

    // Interrupt against an in-flight fetch at 0x40.
    decode(0, 2'd3, 2'd1, 16'd0, 26'd0, 32'h40, 1'b0);
    fetch(4, 1'b1, $urandom(), d);
    check("drop_epc", epc, 32'h40);
    check("drop_addr", bus.imem_addr, IV);
    check("drop_ack", 32'(irq_ack), 32'd1);
    fetch(0, 1'b0, $urandom(), d);

    // Interrupt at accept; then pc_sel=00 overriding a pending interrupt.
    decode(1, 2'd3, 2'd1, 16'd0, 26'd0, 32'h300, 1'b1);
    check("irq_epc", epc, 32'h300);
    check("irq_addr", bus.imem_addr, IV);
    fetch(0, 1'b0, $urandom(), d);
    decode(0, 2'd0, 2'd0, 16'd0, 26'd0, 32'd0, 1'b1);
    check("rst_wins_addr", bus.imem_addr, RV);
    check("rst_wins_noack", 32'(irq_ack), 32'd0);
    fetch(0, 1'b0, $urandom(), d);

    // Reset while in DROP, then a stale ack.
    decode(0, 2'd2, 2'd0, 16'd0, 26'd0, 32'd0, 1'b0);
    irq_req = 1'b1;
    bus.imem_ack = 1'b0;
    tick();
    irq_req = 1'b0;
    do_reset(2, 1'b1);
    check("post_rst_addr", bus.imem_addr, RV);
    fetch(1, 1'b0, $urandom(), d);
    decode(0, 2'd2, 2'd0, 16'd0, 26'd0, 32'd0, 1'b0);

    // Random transactions.
    for (int n = 0; n < 200; n++) begin
      int wt;
      bit irqd;
      wt = $urandom_range(0, 3);
      irqd = (wt > 0) && ($urandom_range(0, 5) == 0);
      fetch(wt, irqd, $urandom(), d);
      if (!d) begin
        decode($urandom_range(0, 3), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               16'($urandom()), 26'($urandom()), $urandom(), ($urandom_range(0, 3) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch sequencer. It consumes the `pc_sel` / `branch_sel` decisions from branch control and computes the next PC. It runs a single-outstanding request/acknowledge fetch to instruction memory, presents fetched instructions to decode with a valid/ready handshake, and redirects to the interrupt vector on `irq_req`.

## Interface
- `RESET_VEC`, default 32'h0000_0000, PC loaded by reset and by `pc_sel`=00
- `INT_VEC`, default 32'h0000_0180, interrupt / `pc_sel`=01 target
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `pc_sel`  in  2  00 reset vector, 01 interrupt vector, 10 PC+4, 11 branch; sampled only on accept
- `branch_sel`  in  2  00 PC+4+offset, 01 register, 10 immediate; 11 treated as PC+4; sampled only on accept
- `branch_offset`  in  16  signed word offset
- `jump_index`  in  26  immediate jump index
- `reg_target`  in  32  register jump target
- `irq_req`  in  1  level interrupt request
- `irq_ack`  out  1  one-cycle pulse when the interrupt is taken
- `epc`  out  32  PC to resume at after the interrupt
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address
- `imem_ack`  in  1  read data valid, same cycle or later
- `imem_rdata`  in  32  instruction word
- `inst_valid`  out  1  instruction presented to decode
- `inst`  out  32  instruction word
- `inst_pc`  out  32  address of `inst`
- `inst_ready`  in  1  decode accepts; accept = `inst_valid & inst_ready`

## Operation
- States:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - HOLD: `inst_valid`=1.
  - DROP: an interrupt is pending against an in-flight fetch.
- FETCH→HOLD on `imem_ack`: capture `inst`←`imem_rdata` and `inst_pc`←`pc`.
- HOLD→FETCH on accept. Load `pc` with the next PC computed from `inst_pc`:
  - `pc_sel` 00 → `RESET_VEC`; 01 → `INT_VEC`; 10 → `inst_pc`+4.
  - `pc_sel` 11 with `branch_sel` 00 → `inst_pc`+4+(sext(`branch_offset`)<<2).
  - `pc_sel` 11 with `branch_sel` 01 → `reg_target`.
  - `pc_sel` 11 with `branch_sel` 10 → {(`inst_pc`+4)[31:28], `jump_index`, 2'b00}.
- Interrupt at accept:
  - Condition: `irq_req`=1 and `pc_sel`≠00.
  - Action: `epc`←computed next PC, `pc`←`INT_VEC`, `irq_ack` pulses.
  - `pc_sel`=00 wins over `irq_req`.
- Interrupt during FETCH (before ack): state→DROP.
  - DROP holds `imem_req`=1 with `imem_addr` unchanged until `imem_ack`.
  - On ack: the word is discarded, `epc`←`pc`, `pc`←`INT_VEC`, `irq_ack` pulses, state→FETCH.
- `irq_req` in HOLD is deferred to accept.
- `irq_req` falling while in DROP does not cancel the interrupt.
- All address arithmetic is 32-bit modulo 2^32; wrap is silent.

## Timing
- Values during reset: `pc`=`RESET_VEC`, state FETCH, `imem_req`=0, `imem_addr`=`RESET_VEC`, `inst_valid`=0, `inst`=0, `inst_pc`=0, `epc`=0, `irq_ack`=0.
- First cycle after reset deasserts: `imem_req`=1, `imem_addr`=`RESET_VEC`.
- `imem_req` and `imem_addr` stay stable until `imem_ack`. Ack in the same cycle as req is legal.
- Ack in cycle N → `inst_valid` high in cycle N+1.
- Accept in cycle M → `imem_req` high with the new address in cycle M+1; `inst_valid` low in M+1.
- Best-case throughput: one instruction per 2 cycles (zero-wait memory, decode always ready).
- `inst`, `inst_pc` and `inst_valid` hold stable while `inst_valid & ~inst_ready`.
- Reset asserted mid-fetch or in HOLD/DROP: reset values are applied next edge. An `imem_ack` that arrives late for the abandoned request is ignored, because `imem_req` is 0 during reset. Memory must honour request withdrawal.
- `irq_ack` is high for exactly one cycle per taken interrupt.

## Structure
- Shared package `pc_fetch_pkg`:
  - `pc_sel` encodings PCSEL_RESET/INT/SEQ/BRANCH.
  - `branch_sel` encodings BSEL_REL/REG/IMM.
  - State enum FETCH/HOLD/DROP.
  - Default vector constants.
- One combinational sub-module, `pc_next_mux`. Inputs: `inst_pc`, `pc_sel`, `branch_sel`, `branch_offset`, `jump_index`, `reg_target`. Output: next PC.
- The top holds the state machine, the PC/instruction registers and the interrupt logic.

## Test plan
- Reset release, zero-wait memory, `pc_sel`=10 every accept → fetch addresses 0x0, 0x4, 0x8; `inst_valid` one cycle after each ack.
- Branch accept at `inst_pc`=0x100, `pc_sel`=11, `branch_sel`=00, offset 16'hFFFE → next `imem_addr`=0xFC. Repeat with `branch_sel`=01, `reg_target`=0x2000 → 0x2000. Repeat with `branch_sel`=10, `jump_index`=26'h40, `inst_pc`=0x1000_0100 → 0x1000_0100.
- Decode stalls 3 cycles with `inst_ready`=0 → `inst`/`inst_pc` stable, `imem_req` stays 0, no extra fetch.
- `irq_req` raised while FETCH at 0x40 waits 4 cycles for ack → word dropped, `epc`=0x40, next `imem_addr`=0x180, single `irq_ack` pulse.
- `irq_req`=1 at accept with `pc_sel`=11 to 0x300 → `epc`=0x300, next fetch 0x180. With `pc_sel`=00 → next fetch `RESET_VEC`, no `irq_ack`.
- Reset asserted during DROP, followed by a stale ack → all outputs at reset values, stale ack ignored, first fetch at `RESET_VEC`.
